// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ      = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Encode a one-hot (or all-zero) vector to its bit index; zero in, zero out.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx |= IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin picker: first unmasked request at or after ptr,
// wrapping from the top index back to 0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset down so the nearest candidate to ptr wins.
  always_comb begin
    cand  = req & ~mask;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      pos = ptr + IDX_W'(i - 1);
      if (cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    onehot      = '0;
    onehot[idx] = found;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and index.
// Optional forced revoke after HOLD_MAX busy cycles: define ARB_TIMEOUT_EN.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,          // owner ends its tenure this cycle
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("rr_arbiter_8: HOLD_MAX must be within 1..255");
  end

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
`ifdef ARB_TIMEOUT_EN
  logic                  timeout_q, timeout_d;
`endif

  logic [IDX_W-1:0]      owner;
  logic                  owner_req;
  logic                  tenure_end;
  logic                  revoke;
  logic [IDX_W-1:0]      pick_ptr;
  logic [N_REQ-1:0]      pick_mask;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [N_REQ-1:0]      pick_oh;

  // Classify the current cycle and steer the picker's search origin and mask.
  // A busy search starts just past the owner, so a re-requesting owner with
  // rel high is naturally last; only a forced revoke masks it out entirely.
  always_comb begin
    owner      = onehot_to_idx(grant_q);
    owner_req  = |(req & grant_q);
    tenure_end = (state_q == BUSY) && (rel || !owner_req);
    revoke     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    revoke     = (state_q == BUSY) && !tenure_end &&
                 (hold_q >= HOLD_CNT_W'(HOLD_MAX - 1));
`endif
    pick_ptr   = (state_q == BUSY) ? owner + IDX_W'(1) : ptr_q;
    pick_mask  = revoke ? grant_q : '0;
  end

  rr_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (pick_mask),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // Next-state: grant from IDLE, hold / hand off / drop in BUSY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_oh;
          idx_d   = pick_idx;
          hold_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tenure_end || revoke) begin
          ptr_d = owner + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          timeout_d = revoke;
`endif
          hold_d = '0;
          if (pick_found) begin
            grant_d = pick_oh;
            idx_d   = pick_idx;
          end else begin
            grant_d = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    grant       = grant_q;
    grant_idx   = idx_q;
    grant_valid = (state_q == BUSY);
`ifdef ARB_TIMEOUT_EN
    timeout     = timeout_q;
`else
    timeout     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8; expected values are hand-derived.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 8'hFF; rel = 1'b0;
    tick(); tick();
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL rst_grant got=%h want=00", grant); end
    total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", grant_idx); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", grant_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
    reset_n = 1'b1; req = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({grant, grant_idx, grant_valid, timeout} !== 13'h0) begin
        bad++; $display("FAIL idle_%0d got=%h/%0d/%b/%b want=00/0/0/0", c, grant, grant_idx, grant_valid, timeout);
      end
    end
  endtask

  task automatic test_single();
    req = 8'h10;
    tick();
    total++; if (grant !== 8'h10) begin bad++; $display("FAIL single_grant got=%h want=10", grant); end
    total++; if (grant_idx !== 3'd4) begin bad++; $display("FAIL single_idx got=%0d want=4", grant_idx); end
    total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", grant_valid); end
    req = 8'h00; rel = 1'b1;
    tick();
    rel = 1'b0;
    total++; if ({grant, grant_idx, grant_valid} !== 12'h0) begin
      bad++; $display("FAIL single_drop got=%h/%0d/%b want=00/0/0", grant, grant_idx, grant_valid);
    end
    // pointer now 5: requester 5 must beat requester 0
    req = 8'h21;
    tick();
    total++; if (grant_idx !== 3'd5) begin bad++; $display("FAIL single_ptr got=%0d want=5", grant_idx); end
    req = 8'h00;
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", grant_valid); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; req = 8'hFF; rel = 1'b0;
    tick();
    total++; if (grant !== 8'h01) begin bad++; $display("FAIL rot_first got=%h want=01", grant); end
    for (int k = 1; k <= 8; k++) begin
      exp_idx = 3'(k % 8);
      rel = 1'b1;
      tick();
      total++; if (grant_idx !== exp_idx) begin bad++; $display("FAIL rot_idx%0d got=%0d want=%0d", k, grant_idx, exp_idx); end
      total++; if (grant !== (8'h01 << exp_idx)) begin bad++; $display("FAIL rot_grant%0d got=%h want=%h", k, grant, 8'h01 << exp_idx); end
      total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL rot_valid%0d got=%b want=1", k, grant_valid); end
      rel = 1'b0;
      tick();
      total++; if (grant_idx !== exp_idx) begin bad++; $display("FAIL rot_hold%0d got=%0d want=%0d", k, grant_idx, exp_idx); end
    end
    req = 8'h00;
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rot_end got=%b want=0", grant_valid); end
  endtask

  task automatic test_wrap();
    req = 8'h40;
    tick();
    total++; if (grant_idx !== 3'd6) begin bad++; $display("FAIL wrap_own got=%0d want=6", grant_idx); end
    req = 8'h41; rel = 1'b1;
    tick();
    total++; if (grant !== 8'h01 || grant_idx !== 3'd0) begin
      bad++; $display("FAIL wrap_to0 got=%h/%0d want=01/0", grant, grant_idx);
    end
    tick();
    total++; if (grant_idx !== 3'd6) begin bad++; $display("FAIL wrap_to6 got=%0d want=6", grant_idx); end
    req = 8'h40;
    tick();
    total++; if (grant !== 8'h40 || grant_valid !== 1'b1) begin
      bad++; $display("FAIL wrap_regrant got=%h/%b want=40/1", grant, grant_valid);
    end
    rel = 1'b0; req = 8'h00;
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL wrap_end got=%b want=0", grant_valid); end
  endtask

  task automatic test_reset_mid();
    req = 8'h08;
    tick();
    total++; if (grant_idx !== 3'd3) begin bad++; $display("FAIL mid_own got=%0d want=3", grant_idx); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
      bad++; $display("FAIL mid_async got=%h/%0d/%b want=00/0/0", grant, grant_idx, grant_valid);
    end
    req = 8'h0C;
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (grant !== 8'h04 || grant_idx !== 3'd2) begin
      bad++; $display("FAIL mid_after got=%h/%0d want=04/2", grant, grant_idx);
    end
    req = 8'h00;
    tick();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL mid_end got=%b want=0", grant_valid); end
  endtask

  task automatic test_timeout();
    // pointer is 3 here; search wraps to requester 0
    req = 8'h03;
    tick();
    total++; if (grant_idx !== 3'd0 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_start got=%0d/%b want=0/0", grant_idx, timeout);
    end
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (grant_idx !== 3'd0 || timeout !== 1'b0) begin
        bad++; $display("FAIL to_hold%0d got=%0d/%b want=0/0", c, grant_idx, timeout);
      end
    end
    tick();
    total++; if (grant !== 8'h02 || grant_idx !== 3'd1 || timeout !== 1'b1) begin
      bad++; $display("FAIL to_revoke got=%h/%0d/%b want=02/1/1", grant, grant_idx, timeout);
    end
    tick();
    total++; if (grant_idx !== 3'd1 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_pulse got=%0d/%b want=1/0", grant_idx, timeout);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      total++; if (grant_idx !== 3'd0 || timeout !== 1'b0 || grant_valid !== 1'b1) begin
        bad++; $display("FAIL nto_hold%0d got=%0d/%b/%b want=0/0/1", c, grant_idx, timeout, grant_valid);
      end
    end
`endif
    req = 8'h00;
    tick();
    total++; if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_end got=%b/%b want=0/0", grant_valid, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
